// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : voice_mixer
//  Purpose  : Sums NUM_VOICES signed 24-bit voice samples one voice per cycle,
//             scales the sum by an unsigned Q1.7 master gain, attenuates by an
//             arithmetic right shift and saturates to a signed 24-bit sample.
//             Fixed latency: tick at cycle t -> mix_valid at t+NUM_VOICES+3.
//  Options  : define VOICE_MIXER_GATE_EN to mute voices whose snapshot
//             voice_done bit is set (cycle count and latency unchanged).
//  Revision : 1.0 - initial release
// ============================================================================
module voice_mixer #(
  parameter int NUM_VOICES  = 4,   // voices summed per sample (2..16)
  parameter int ATTEN_SHIFT = 2    // extra right shift applied after gain
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [24*NUM_VOICES-1:0]   voice_in,
  input  logic [NUM_VOICES-1:0]      voice_done,
  input  logic [7:0]                 master_gain,
  input  logic                       overrun_clr,
  output logic signed [23:0]         mix_out,
  output logic                       mix_valid,
  output logic                       busy,
  output logic                       overrun
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  // Voice index width; NUM_VOICES >= 2 so this is always at least 1 bit.
  localparam int C_IDX_W  = $clog2(NUM_VOICES);
  // One guard bit beyond the clog2 growth keeps the sum of NUM_VOICES
  // full-scale negative samples representable without wrap.
  localparam int C_ACC_W  = 24 + C_IDX_W + 1;
  // Accumulator times a 9-bit signed (zero-extended) gain.
  localparam int C_PROD_W = C_ACC_W + 9;
  // Q1.7 gain brings 7 fractional bits; ATTEN_SHIFT is added on top.
  localparam int C_SHIFT  = 7 + ATTEN_SHIFT;

  localparam logic [C_IDX_W-1:0]         C_LAST_IDX = C_IDX_W'(NUM_VOICES - 1);
  localparam logic [C_IDX_W-1:0]         C_IDX_ONE  = C_IDX_W'(1);
  localparam logic signed [C_PROD_W-1:0] C_MAX      = C_PROD_W'(8388607);
  localparam logic signed [C_PROD_W-1:0] C_MIN      = C_PROD_W'(-8388608);
  localparam logic signed [23:0]         C_OUT_MAX  = 24'sh7FFFFF;
  localparam logic signed [23:0]         C_OUT_MIN  = 24'sh800000;

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    SAT   = 2'd3
  } state_t;

  state_t                      r_state;

  // Snapshot of the inputs taken on the accepted tick; the mix in flight only
  // ever reads these, so later input changes cannot disturb it.
  logic [24*NUM_VOICES-1:0]    r_voices;
  logic [NUM_VOICES-1:0]       r_done;
  logic [7:0]                  r_gain;

  logic [C_IDX_W-1:0]          r_idx;
  logic signed [C_ACC_W-1:0]   r_acc;
  logic signed [C_PROD_W-1:0]  r_scaled;

  // --------------------------------------------------------------------------
  // Voice selection datapath
  // --------------------------------------------------------------------------
  logic signed [23:0]          w_voice_arr [NUM_VOICES];
  logic signed [23:0]          w_cur_voice;
  logic signed [C_ACC_W-1:0]   w_cur_ext;
  logic signed [C_ACC_W-1:0]   w_addend;

  // Unpack the flat snapshot bus into one lane per voice.
  generate
    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice_lane
      assign w_voice_arr[k] = r_voices[24*k +: 24];
    end
  endgenerate

  // r_idx never exceeds NUM_VOICES-1, so the lookup is always in range.
  assign w_cur_voice = w_voice_arr[r_idx];
  assign w_cur_ext   = {{(C_ACC_W-24){w_cur_voice[23]}}, w_cur_voice};

`ifdef VOICE_MIXER_GATE_EN
  // Finished voices still take their accumulate slot but add nothing, so the
  // cycle count does not depend on which voices are active.
  assign w_addend = r_done[r_idx] ? '0 : w_cur_ext;
`else
  // Gating disabled: every voice contributes. The done snapshot is kept so
  // both builds share the same register map; fold it into a sink net.
  logic w_unused_done;
  assign w_unused_done = ^r_done;
  assign w_addend      = w_cur_ext;
`endif

  // --------------------------------------------------------------------------
  // Gain and attenuation datapath
  // --------------------------------------------------------------------------
  logic signed [C_PROD_W-1:0]  w_gain_ext;
  logic signed [C_PROD_W-1:0]  w_product;
  logic signed [C_PROD_W-1:0]  w_shifted;
  logic signed [23:0]          w_clamped;

  // Gain is unsigned; a zero MSB makes it a non-negative signed operand.
  assign w_gain_ext = C_PROD_W'($signed({1'b0, r_gain}));
  // Full-width signed product; the true product always fits in C_PROD_W.
  assign w_product  = C_PROD_W'(r_acc) * w_gain_ext;
  // Pure arithmetic shift: rounds toward negative infinity.
  assign w_shifted  = w_product >>> C_SHIFT;

  // Saturate the scaled result into the signed 24-bit output range.
  always_comb begin
    w_clamped = r_scaled[23:0];
    if (r_scaled > C_MAX) begin
      w_clamped = C_OUT_MAX;
    end else if (r_scaled < C_MIN) begin
      w_clamped = C_OUT_MIN;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  // Sequences snapshot -> accumulate -> scale -> saturate and owns all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_voices  <= '0;
      r_done    <= '0;
      r_gain    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_scaled  <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;

      // A tick outside IDLE (including the SAT cycle) is dropped and flagged;
      // setting takes priority over a simultaneous clear.
      if (sample_tick && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_voices <= voice_in;
            r_done   <= voice_done;
            r_gain   <= master_gain;
            r_acc    <= '0;
            r_idx    <= '0;
            busy     <= 1'b1;
            r_state  <= ACCUM;
          end
        end

        ACCUM: begin
          r_acc <= r_acc + w_addend;
          if (r_idx == C_LAST_IDX) begin
            r_state <= SCALE;
          end else begin
            r_idx <= r_idx + C_IDX_ONE;
          end
        end

        SCALE: begin
          r_scaled <= w_shifted;
          r_state  <= SAT;
        end

        SAT: begin
          mix_out   <= w_clamped;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_mixer
//  Purpose  : Scoreboard bench for voice_mixer (NUM_VOICES=4, ATTEN_SHIFT=2).
//             Stimulus pushes hand-computed results into a queue; a monitor
//             pops and compares value and arrival cycle on every mix_valid.
//             With ATTEN_SHIFT=2 the total shift after gain is 9 bits.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mixer;

  localparam int NV  = 4;
  localparam int LAT = NV + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_tick;
  logic [24*NV-1:0]  voice_in;
  logic [NV-1:0]     voice_done;
  logic [7:0]        master_gain;
  logic              overrun_clr;
  logic [23:0]       mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] val;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  voice_mixer #(
    .NUM_VOICES  (NV),
    .ATTEN_SHIFT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_in    (voice_in),
    .voice_done  (voice_done),
    .master_gain (master_gain),
    .overrun_clr (overrun_clr),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Cycle counter: during the cycle following posedge k it reads k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every mix_valid pulse must match the oldest expected result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && mix_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: mix_valid at cycle %0d with mix_out 0x%0h, expected no pulse", cyc, mix_out);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_value"}, {8'h00, mix_out}, {8'h00, e.val});
          check({e.name, "_latency"}, cyc, e.due);
        end
      end
    end
  end

  // Issue one tick with the given inputs; call right after a negedge.
  task automatic start_mix(input logic [24*NV-1:0] vin, input logic [NV-1:0] dn,
                           input logic [7:0] g, input logic [23:0] ev,
                           input bit expect_out, input string nm);
    exp_t e;
    voice_in    = vin;
    voice_done  = dn;
    master_gain = g;
    sample_tick = 1'b1;
    if (expect_out) begin
      e.val  = ev;
      e.due  = cyc + LAT;
      e.name = nm;
      exp_q.push_back(e);
    end
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Wait (bounded) until all expected results have arrived and DUT is idle.
  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results still pending, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Global safety net in case something stalls outside a bounded wait.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] gate_exp;
    rst         = 1'b1;
    sample_tick = 1'b0;
    voice_in    = '0;
    voice_done  = '0;
    master_gain = 8'd0;
    overrun_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mix_out",   {8'h00, mix_out}, 32'h0);
    check("rst_mix_valid", {31'h0, mix_valid}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unity gain: 4 * 0x100000 * 128 >> 9 = 0x100000
    start_mix({4{24'h100000}}, 4'h0, 8'd128, 24'h100000, 1'b1, "unity");
    check("busy_during_mix", {31'h0, busy}, 32'h1);
    drain("unity");

    // Saturation in both directions
    start_mix({4{24'h7FFFFF}}, 4'h0, 8'd255, 24'h7FFFFF, 1'b1, "pos_clamp");
    drain("pos_clamp");
    start_mix({4{24'h800000}}, 4'h0, 8'd255, 24'h800000, 1'b1, "neg_clamp");
    drain("neg_clamp");

    // Zero gain gives zero
    start_mix({4{24'h123456}}, 4'h0, 8'd0, 24'h000000, 1'b1, "gain_zero");
    drain("gain_zero");

    // Rounding toward -inf: -1*1>>9 = -1; -1000*1>>9 = -2; 1*128>>9 = 0
    start_mix({72'h0, 24'hFFFFFF}, 4'h0, 8'd1, 24'hFFFFFF, 1'b1, "round_m1");
    drain("round_m1");
    start_mix({72'h0, 24'hFFFC18}, 4'h0, 8'd1, 24'hFFFFFE, 1'b1, "round_m1000");
    drain("round_m1000");
    start_mix({72'h0, 24'h000001}, 4'h0, 8'd128, 24'h000000, 1'b1, "round_p1");
    drain("round_p1");

    // Mixed signs: (0x100000 - 0x100000 + 0x040000) * 64 >> 9 = 0x008000
    start_mix({24'h000000, 24'h040000, 24'hF00000, 24'h100000}, 4'h0, 8'd64,
              24'h008000, 1'b1, "mixed");
    drain("mixed");

    // Voice 2 flagged done: muted only when gating is built in
`ifdef VOICE_MIXER_GATE_EN
    gate_exp = 24'h000000;
`else
    gate_exp = 24'h080000;
`endif
    start_mix({24'h0, 24'h200000, 24'h0, 24'h0}, 4'b0100, 8'd128, gate_exp, 1'b1, "gate");
    drain("gate");

    // Inputs changed one cycle after the tick must not affect the result
    start_mix({4{24'h100000}}, 4'h0, 8'd128, 24'h100000, 1'b1, "snapshot");
    voice_in    = {4{24'h7FFFFF}};
    master_gain = 8'd255;
    voice_done  = 4'hF;
    drain("snapshot");

    // Tick at t and t+3: one result, overrun sticky, then cleared
    start_mix({4{24'h040000}}, 4'h0, 8'd128, 24'h040000, 1'b1, "ovr_a");
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("ovr_set", {31'h0, overrun}, 32'h1);
    drain("ovr_a");
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", {31'h0, overrun}, 32'h0);

    // Set beats clear in the same cycle; tick in SAT is an overrun only
    start_mix({4{24'h100000}}, 4'h0, 8'd128, 24'h100000, 1'b1, "ovr_b");  // now t+1
    @(negedge clk);                                                          // t+2
    sample_tick = 1'b1;
    @(negedge clk);                                                          // t+3
    overrun_clr = 1'b1;
    @(negedge clk);                                                          // t+4
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", {31'h0, overrun}, 32'h1);
    overrun_clr = 1'b1;
    @(negedge clk);                                                          // t+5
    overrun_clr = 1'b0;
    check("ovr_clr_b", {31'h0, overrun}, 32'h0);
    @(negedge clk);                                                          // t+6 (SAT)
    check("busy_in_sat", {31'h0, busy}, 32'h1);
    sample_tick = 1'b1;
    @(negedge clk);                                                          // t+7
    sample_tick = 1'b0;
    check("ovr_sat_tick", {31'h0, overrun}, 32'h1);
    check("busy_after_mix", {31'h0, busy}, 32'h0);
    drain("ovr_b");
    repeat (12) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Reset mid-mix aborts without a pulse and clears outputs
    start_mix({4{24'h7FFFFF}}, 4'h0, 8'd128, 24'h0, 1'b0, "abort");        // now t+1
    repeat (3) @(negedge clk);                                               // t+4
    rst = 1'b1;
    #1;
    check("abort_busy",    {31'h0, busy}, 32'h0);
    check("abort_mix_out", {8'h00, mix_out}, 32'h0);
    check("abort_valid",   {31'h0, mix_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle_out", {8'h00, mix_out}, 32'h0);

    // Fresh mix after reset: 4 * 0x020000 * 128 >> 9 = 0x020000
    start_mix({4{24'h020000}}, 4'h0, 8'd128, 24'h020000, 1'b1, "post_rst");
    drain("post_rst");

    check("queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of notebank voices summed (2..16).
REQ-002 SHALL have parameter ATTEN_SHIFT, default 2, arithmetic right shift applied after gain.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sample_tick  in  1  one-cycle strobe requesting one mixed sample.
REQ-006 SHALL have port voice_in  in  24*NUM_VOICES  signed 24-bit voice samples, voice k at bits [24k+23:24k].
REQ-007 SHALL have port voice_done  in  NUM_VOICES  per-voice envelope-finished flag.
REQ-008 SHALL have port master_gain  in  8  unsigned Q1.7 gain; 128 = unity.
REQ-009 SHALL have port overrun_clr  in  1  clears the sticky overrun flag.
REQ-010 SHALL have port mix_out  out  24  signed mixed sample, held between updates.
REQ-011 SHALL have port mix_valid  out  1  one-cycle pulse when mix_out updates.
REQ-012 SHALL have port busy  out  1  high while a mix is in progress.
REQ-013 SHALL have port overrun  out  1  sticky; a tick arrived while busy.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, SCALE, SAT.
REQ-015 IDLE: on sample_tick SHALL snapshot voice_in, voice_done and master_gain into registers, clear accumulator and voice index, go to ACCUM.
REQ-016 ACCUM: SHALL add one sign-extended snapshot voice per cycle, index 0 upward; after voice NUM_VOICES-1, go to SCALE.
REQ-017 Accumulator SHALL be 24+clog2(NUM_VOICES)+1 bits signed; no wrap for any input.
REQ-018 SCALE: SHALL compute product = accumulator * {1'b0, gain}, signed, full width; then arithmetic shift right by 7+ATTEN_SHIFT; go to SAT.
REQ-019 SAT: SHALL clamp the shifted result to [-8388608, 8388607], load mix_out, pulse mix_valid for one cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: tick at cycle t gives mix_valid at cycle t+NUM_VOICES+3.
REQ-021 busy SHALL be high in ACCUM, SCALE and SAT, and low in IDLE.
REQ-022 A sample_tick while busy SHALL be ignored and SHALL set overrun; the mix in flight SHALL complete unchanged.
REQ-023 overrun_clr SHALL clear overrun; if a set condition occurs in the same cycle, set SHALL win.
REQ-024 A sample_tick in the SAT cycle SHALL count as overrun, not as a new mix.
REQ-025 Inputs changing after the tick cycle SHALL NOT affect the result in flight.
REQ-026 master_gain = 0 SHALL give mix_out = 0; rounding SHALL be toward negative infinity (pure arithmetic shift).

Reset
REQ-027 While rst is high, SHALL hold state IDLE, mix_out = 0, mix_valid = 0, busy = 0, overrun = 0, and clear accumulator, index and snapshots.
REQ-028 rst asserted mid-mix SHALL abort the mix with no mix_valid pulse; the first tick after release SHALL start a fresh mix.

Configuration
REQ-029 Macro VOICE_MIXER_GATE_EN defined: voices whose snapshot voice_done bit is 1 SHALL contribute 0 in ACCUM; cycle count and latency unchanged.
REQ-030 Macro VOICE_MIXER_GATE_EN undefined: voice_done SHALL be ignored and all voices summed.

Verification
REQ-031 4 voices = 0x100000 each, gain 128, shift 2, tick -> mix_valid at t+7, mix_out = 0x100000.
REQ-032 4 voices = 0x7FFFFF, gain 255, shift 0 -> mix_out = 0x7FFFFF (positive clamp); all 0x800000 -> 0x800000 (negative clamp).
REQ-033 Tick at t and again at t+3 -> single mix_valid at t+7, overrun = 1; overrun_clr pulse -> overrun = 0.
REQ-034 Voice 2 = 0x200000, voice_done = 4'b0100, others 0, gain 128, shift 0 -> mix_out = 0 with VOICE_MIXER_GATE_EN, 0x200000 without.
REQ-035 rst pulse at t+4 of a mix -> no mix_valid, mix_out = 0, busy = 0; next tick mixes normally.
REQ-036 voice_in changed at t+1 after tick at t -> mix_out reflects values sampled at t.
